// File: rtl/user_data_check.sv
// user_data_check: read-side checker for the DDR loopback test (incrementing modulo-2^W counter)
// Ports:
//   sys_clk, sys_rst_n     clock (rising edge), asynchronous active-low reset
//   i_ddrc_init_done       DDR calibrated; pops are only issued while high
//   i_rd_test_ctrl         one-cycle pulse: start a run from IDLE/DONE, abort it from SYNC/CHECK
//   i_fifo_read_empty      read FIFO empty
//   o_fifo_read_en         FIFO pop strobe, one word per asserted cycle
//   i_fifo_read_data       FIFO data, valid RD_LATENCY cycles after the pop
//   o_check_busy           high in SYNC or CHECK
//   o_check_done           run completed; sticky until the next start or reset
//   o_check_pass           valid with o_check_done: no mismatches
//   o_err_cnt              saturating mismatch count for this run
//   o_word_cnt             words consumed this run, SYNC word included
//   o_first_err_exp/act    expected/received value at the first mismatch
module user_data_check #(
  parameter int USER_DATA_WIDTH = 8,
  parameter int CHECK_WORDS     = 1024,
  parameter int RD_LATENCY      = 1,
  parameter int ERR_CNT_WIDTH   = 16,
  parameter bit STOP_ON_ERR     = 1'b0
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       i_ddrc_init_done,
  input  logic                       i_rd_test_ctrl,
  input  logic                       i_fifo_read_empty,
  output logic                       o_fifo_read_en,
  input  logic [USER_DATA_WIDTH-1:0] i_fifo_read_data,
  output logic                       o_check_busy,
  output logic                       o_check_done,
  output logic                       o_check_pass,
  output logic [ERR_CNT_WIDTH-1:0]   o_err_cnt,
  output logic [31:0]                o_word_cnt,
  output logic [USER_DATA_WIDTH-1:0] o_first_err_exp,
  output logic [USER_DATA_WIDTH-1:0] o_first_err_act
);
  typedef enum logic [1:0] {IDLE, SYNC, CHECK, DONE} state_t;
  state_t r_state, w_next;
  logic [31:0] r_issued;
  logic [RD_LATENCY-1:0] r_vld;
  logic [RD_LATENCY:0] w_vld_shift;
  logic [USER_DATA_WIDTH-1:0] r_expected;
  logic w_run, w_run_next, w_consume, w_mismatch, w_finish;
  assign w_run = r_state == SYNC || r_state == CHECK;
  assign w_run_next = w_next == SYNC || w_next == CHECK;
  assign o_check_busy = w_run;
  assign o_fifo_read_en = w_run && i_ddrc_init_done && !i_fifo_read_empty && r_issued < 32'(CHECK_WORDS);
  // top bit of the shift is the valid flag of the word on i_fifo_read_data this cycle
  assign w_vld_shift = {r_vld, o_fifo_read_en};
  // an abort in the same cycle wins, so the word arriving with it is dropped
  assign w_consume = w_run && !i_rd_test_ctrl && w_vld_shift[RD_LATENCY];
  assign w_mismatch = r_state == CHECK && w_consume && i_fifo_read_data != r_expected;
  assign w_finish = r_state == CHECK && w_consume &&
                    (o_word_cnt + 32'd1 == 32'(CHECK_WORDS) || (STOP_ON_ERR && w_mismatch));
  always_comb begin
    w_next = r_state;
    if (!w_run)
      w_next = (i_rd_test_ctrl && i_ddrc_init_done) ? SYNC : r_state;
    else
      w_next = i_rd_test_ctrl ? IDLE : (r_state == SYNC && w_consume) ? CHECK : w_finish ? DONE : r_state;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state         <= IDLE;
      r_issued        <= '0;
      r_vld           <= '0;
      r_expected      <= '0;
      o_check_done    <= 1'b0;
      o_check_pass    <= 1'b0;
      o_err_cnt       <= '0;
      o_word_cnt      <= '0;
      o_first_err_exp <= '0;
      o_first_err_act <= '0;
    end else begin
      r_state <= w_next;
      // leaving the run drops every word still in flight
      r_vld <= w_run_next ? w_vld_shift[RD_LATENCY-1:0] : '0;
      if (!w_run && w_next == SYNC) begin
        r_issued        <= '0;
        o_check_done    <= 1'b0;
        o_check_pass    <= 1'b0;
        o_err_cnt       <= '0;
        o_word_cnt      <= '0;
        o_first_err_exp <= '0;
        o_first_err_act <= '0;
      end else begin
        if (o_fifo_read_en)
          r_issued <= r_issued + 32'd1;
        // expected advances from the sync word independently of received data,
        // so one corrupt word is one error and does not disturb the following compares
        if (w_consume) begin
          o_word_cnt <= r_state == SYNC ? 32'd1 : o_word_cnt + 32'd1;
          r_expected <= r_state == SYNC ? i_fifo_read_data + USER_DATA_WIDTH'(1) : r_expected + USER_DATA_WIDTH'(1);
        end
        if (w_mismatch) begin
          o_err_cnt <= &o_err_cnt ? o_err_cnt : o_err_cnt + ERR_CNT_WIDTH'(1);
          if (o_err_cnt == '0) begin
            o_first_err_exp <= r_expected;
            o_first_err_act <= i_fifo_read_data;
          end
        end
        if (w_finish) begin
          o_check_done <= 1'b1;
          o_check_pass <= o_err_cnt == '0 && !w_mismatch;
        end
      end
    end
  end
endmodule

// File: tb/tb_user_data_check.sv
// tb_user_data_check: scoreboard bench for user_data_check over three configurations
module tb_user_data_check;
  localparam int N = 16;
  typedef logic [7:0] q8_t[$];
  typedef struct {
    int inst; logic done; logic pass; int err; int wc;
    logic [7:0] fe; logic [7:0] fa; int pops; int p0;
  } res_t;
  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  logic rst_n[3], base_init[3], ctrl[3], stall_en[3];
  logic st_e[3], st_i[3], emp[3], init[3];
  logic en[3], busy[3], done[3], pass[3];
  logic [15:0] errc[3];
  logic [31:0] wcnt[3];
  logic [7:0] fe[3], fa[3], rdata[3];
  logic [7:0] fq[3][$];
  int pops[3];
  res_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int g, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%0d required=%0d", nm, g, act, exp);
    end
  endtask

  // instance 0: latency 1, 1: latency 1 with stop-on-error, 2: latency 3
  for (genvar g = 0; g < 3; g++) begin : h
    localparam int L = (g == 2) ? 3 : 1;
    logic [7:0] dp[L];
    logic pb = 1'b0;
    assign init[g] = base_init[g] & ~st_i[g];
    assign rdata[g] = dp[L-1];
    user_data_check #(
      .USER_DATA_WIDTH(8), .CHECK_WORDS(N), .RD_LATENCY(L),
      .ERR_CNT_WIDTH(16), .STOP_ON_ERR(g == 1)
    ) dut (
      .sys_clk(sys_clk), .sys_rst_n(rst_n[g]),
      .i_ddrc_init_done(init[g]), .i_rd_test_ctrl(ctrl[g]),
      .i_fifo_read_empty(emp[g]), .o_fifo_read_en(en[g]),
      .i_fifo_read_data(rdata[g]), .o_check_busy(busy[g]),
      .o_check_done(done[g]), .o_check_pass(pass[g]),
      .o_err_cnt(errc[g]), .o_word_cnt(wcnt[g]),
      .o_first_err_exp(fe[g]), .o_first_err_act(fa[g])
    );
    always @(posedge sys_clk) begin
      for (int i = L - 1; i > 0; i--) dp[i] <= dp[i-1];
      if (en[g]) begin
        pops[g] <= pops[g] + 1;
        dp[0] <= fq[g].size() > 0 ? fq[g].pop_front() : 8'h00;
      end
    end
    always @(negedge sys_clk) begin
      st_e[g] = stall_en[g] && busy[g] && $urandom_range(3) == 0;
      st_i[g] = stall_en[g] && busy[g] && $urandom_range(7) == 0;
    end
    always @(negedge sys_clk) begin
      #1;
      emp[g] = st_e[g] || fq[g].size() == 0;
    end
    always @(negedge sys_clk) begin
      #3;
      if (busy[g] && (emp[g] || !init[g])) chk("pop_while_blocked", g, en[g], 0);
    end
    always @(negedge sys_clk) begin : mon
      res_t r;
      if (pb && !busy[g]) begin
        if (sb.size() == 0) chk("unexpected_run_end", g, 1, 0);
        else begin
          r = sb.pop_front();
          chk("inst", g, g, r.inst);
          chk("done", g, done[g], r.done);
          chk("pass", g, pass[g], r.pass);
          chk("err_cnt", g, errc[g], r.err);
          chk("word_cnt", g, wcnt[g], r.wc);
          chk("first_err_exp", g, fe[g], r.fe);
          chk("first_err_act", g, fa[g], r.fa);
          chk("read_en_after_end", g, en[g], 0);
          if (r.pops >= 0) chk("pops", g, pops[g] - r.p0, r.pops);
        end
      end
      pb = busy[g];
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge sys_clk);
  endtask

  function automatic q8_t ramp(input logic [7:0] b);
    q8_t q;
    for (int i = 0; i < N; i++) q.push_back(b + 8'(i));
    return q;
  endfunction

  // word i of a run is expected to be sync word + i (mod 256); word 0 only syncs
  function automatic res_t model(input int k, input q8_t s, input int abort_at);
    res_t r;
    bit stop = (k == 1);
    r.inst = k; r.done = 0; r.pass = 0; r.err = 0; r.wc = 1;
    r.fe = 0; r.fa = 0; r.pops = -1; r.p0 = pops[k];
    for (int i = 1; i < s.size() && r.wc < N && r.wc != abort_at; i++) begin
      logic [7:0] e;
      e = s[0] + 8'(i);
      r.wc++;
      if (s[i] != e) begin
        if (r.err == 0) begin r.fe = e; r.fa = s[i]; end
        r.err++;
      end
      if (stop && r.err > 0) break;
    end
    if (abort_at == 0) begin
      r.done = 1;
      r.pass = r.err == 0;
      if (!(stop && r.err > 0)) r.pops = N;
    end
    return r;
  endfunction

  task automatic wait_empty(input int k);
    int t = 0;
    while (sb.size() != 0 && t < 3000) begin tick(); t++; end
    chk("run_complete", k, sb.size(), 0);
    sb.delete();
    tick(2);
  endtask

  task automatic pulse(input int k);
    ctrl[k] = 1'b1; tick(); ctrl[k] = 1'b0;
  endtask

  task automatic run(input int k, input q8_t s, input int abort_at, input bit stall);
    fq[k].delete();
    foreach (s[i]) fq[k].push_back(s[i]);
    stall_en[k] = stall;
    sb.push_back(model(k, s, abort_at));
    tick(2);
    pulse(k);
    if (abort_at > 0) begin
      int t = 0;
      while (wcnt[k] != 32'(abort_at) && t < 2000) begin tick(); t++; end
      if (t >= 2000) chk("abort_wait", k, t, 0);
      pulse(k);
    end
    wait_empty(k);
    stall_en[k] = 1'b0;
    fq[k].delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    q8_t s;
    res_t z;
    for (int g = 0; g < 3; g++) begin
      rst_n[g] = 1'b0; base_init[g] = 1'b1; ctrl[g] = 1'b0; stall_en[g] = 1'b0;
    end
    tick(3);
    for (int g = 0; g < 3; g++) begin
      chk("rst_ctl", g, {en[g], busy[g], done[g], pass[g]}, 0);
      chk("rst_cnt", g, {errc[g], wcnt[g]}, 0);
      chk("rst_first_err", g, {fe[g], fa[g]}, 0);
      rst_n[g] = 1'b1;
    end
    tick(2);
    run(0, ramp(8'd5), 0, 0);
    run(0, ramp(8'd250), 0, 0);
    s = ramp(8'd0); s[7] = 8'h55;
    run(0, s, 0, 0);
    run(1, s, 0, 0);
    run(0, ramp(8'($urandom)), 6, 1);
    run(0, ramp(8'($urandom)), 0, 1);
    base_init[0] = 1'b0;
    pulse(0);
    tick(2);
    chk("start_ignored_without_init", 0, busy[0], 0);
    base_init[0] = 1'b1;
    s = ramp(8'd0);
    foreach (s[i]) fq[0].push_back(s[i]);
    z.inst = 0; z.done = 0; z.pass = 0; z.err = 0; z.wc = 0;
    z.fe = 0; z.fa = 0; z.pops = -1; z.p0 = 0;
    sb.push_back(z);
    pulse(0);
    for (int t = 0; t < 2000 && wcnt[0] != 32'd5; t++) tick();
    #2 rst_n[0] = 1'b0;
    tick(2);
    rst_n[0] = 1'b1;
    wait_empty(0);
    fq[0].delete();
    run(2, ramp(8'd5), 0, 0);
    s = ramp(8'd0); s[7] = 8'h55;
    run(2, s, 0, 1);
    for (int n = 0; n < 8; n++) begin
      int k;
      k = int'($urandom_range(2));
      s = ramp(8'($urandom));
      foreach (s[i]) if ($urandom_range(9) == 0) s[i] = 8'($urandom);
      run(k, s, 0, 1'($urandom_range(1)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
